// File: rtl/sample_tff_pkg.sv
// Shared constants and the Gray-code helper for the sample_tff toggle counter.
package sample_tff_pkg;

    localparam logic DIR_UP       = 1'b1;
    localparam logic DIR_DN       = 1'b0;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Callers truncate the result to their own width.
    function automatic logic [31:0] to_gray(input logic [31:0] x);
        return x ^ (x >> 1);
    endfunction

endpackage

// File: rtl/sample_tff_nextstate.sv
// Combinational next-count and terminal detection for the toggle counter.
module sample_tff_nextstate
    import sample_tff_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic [WIDTH-1:0] max,
    output logic             terminal,
    output logic [WIDTH-1:0] step_q,
    output logic [WIDTH-1:0] wrap_q
);

    always_comb begin
        terminal = 1'b0;
        step_q   = q;
        wrap_q   = q;
        if (up == DIR_UP) begin
            // >= so that a loaded value above MAX still counts as terminal.
            terminal = (q >= max);
            step_q   = q + WIDTH'(1);
            wrap_q   = '0;
        end else begin
            terminal = (q == '0);
            step_q   = q - WIDTH'(1);
            wrap_q   = max;
        end
    end

endmodule

// File: rtl/sample_tff_counter.sv
// WIDTH-bit toggle counter: CLR > LOAD > EN priority, wrap/one-shot modes, registered TC/DONE/Gray.
module sample_tff_counter
    import sample_tff_pkg::*;
#(
    parameter int          WIDTH   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             UP,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic [WIDTH-1:0] MAX,
    input  logic             ONESHOT,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_GRAY,
    output logic             TC,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] RST_Q    = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(to_gray(RST_VAL));

    logic             terminal;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] wrap_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_d;
    logic             done_d;

    sample_tff_nextstate #(.WIDTH(WIDTH)) u_nextstate (
        .q        (Q),
        .up       (UP),
        .max      (MAX),
        .terminal (terminal),
        .step_q   (step_q),
        .wrap_q   (wrap_q)
    );

    always_comb begin
        q_d    = Q;
        tc_d   = 1'b0;
        done_d = DONE;
        if (CLR) begin
            q_d    = '0;
            done_d = 1'b0;
        end else if (LOAD) begin
            q_d    = DIN;
            done_d = 1'b0;
        end else if (EN && !DONE) begin
            if (!terminal) begin
                q_d = step_q;
            end else if (ONESHOT == MODE_WRAP) begin
                q_d  = wrap_q;
                tc_d = 1'b1;
            end else begin
                tc_d   = 1'b1;
                done_d = 1'b1;
            end
        end
    end

    // Gray copy is taken from the next-state value so it lands on the same edge as Q.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Q      <= RST_Q;
            Q_GRAY <= RST_GRAY;
            TC     <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            Q      <= q_d;
            Q_GRAY <= WIDTH'(to_gray(32'(q_d)));
            TC     <= tc_d;
            DONE   <= done_d;
        end
    end

endmodule

// File: doc/sample_tff_counter.md
Name: sample_tff_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit toggle counter.
- Features: enable (T input), up/down direction, synchronous load and clear, programmable terminal value, wrap or one-shot mode.
- Outputs: registered terminal-count pulse, sticky done flag, and a Gray-coded copy of the count.
- Used as the general event/timebase counter in lab designs, in place of chained single-bit toggle flops.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- RST_VAL, 0, value of Q after asynchronous reset. Must be <= 2^WIDTH-1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous assertion, active-low. Required exactly so: one clock, asynchronous active-low reset.
- EN  in  1  count enable (toggle input); the counter steps only when EN=1.
- UP  in  1  direction: 1=increment, 0=decrement.
- CLR  in  1  synchronous clear to 0.
- LOAD  in  1  synchronous load of DIN.
- DIN  in  WIDTH  load value.
- MAX  in  WIDTH  terminal value; the count range is 0..MAX.
- ONESHOT  in  1  0=wrap mode, 1=stop at terminal.
- Q  out  WIDTH  count value.
- Q_GRAY  out  WIDTH  Gray code of Q, registered, cycle-aligned with Q.
- TC  out  1  terminal-count pulse.
- DONE  out  1  sticky one-shot completion flag.

Behaviour:
- Reset (RST=0, asynchronous): Q=RST_VAL, Q_GRAY=gray(RST_VAL), TC=0, DONE=0. Reset takes effect immediately mid-count. Release is synchronous to the next rising edge.
- Priority per edge: CLR > LOAD > EN. With none asserted, all registers hold, and TC drops to 0.
- CLR: Q=0, Q_GRAY=0, TC=0, DONE=0.
- LOAD: Q=DIN, Q_GRAY=gray(DIN), TC=0, DONE=0. DIN>MAX is accepted as-is.
- Terminal condition:
  - Up: Q>=MAX.
  - Down: Q==0.
- EN=1, not terminal: Q=Q+1 (up) or Q-1 (down), with modulo-2^WIDTH arithmetic. TC=0.
- EN=1, terminal, ONESHOT=0:
  - Q wraps: up gives 0, down gives MAX.
  - TC=1 for exactly that one cycle, coincident with Q showing the wrapped value.
- EN=1, terminal, ONESHOT=1, DONE=0:
  - Q holds.
  - TC=1 for one cycle and DONE=1 on the same edge.
- DONE=1: EN is ignored and Q holds. TC stays 0. Only CLR, LOAD or reset clear DONE.
- ONESHOT is sampled every edge; changing it mid-count takes effect on the next terminal event. Clearing ONESHOT while DONE=1 does not clear DONE.
- MAX may change at any time; it is compared combinationally each edge.
  - If MAX=0, up-count gives Q=0 with TC=1 every enabled cycle (wrap mode).
- Latency: one cycle from EN/LOAD/CLR to Q, Q_GRAY, TC and DONE. There are no combinational paths from inputs to outputs.
- Q_GRAY is computed from the next-state value and registered, never derived from Q combinationally.
- UP toggling on the same edge as EN uses the new UP value for that step.

Decomposition:
- Package sample_tff_pkg holds:
  - function to_gray(x) = x ^ (x>>1);
  - localparams DIR_UP=1'b1, DIR_DN=1'b0, MODE_WRAP=1'b0, MODE_ONESHOT=1'b1.
- One natural sub-module: sample_tff_nextstate, the combinational next-Q / terminal-detect logic. The top holds only registers and priority.

Test Plan (WIDTH=4, RST_VAL=0):
- Reset, then EN=1, UP=1, MAX=5, ONESHOT=0 for 8 cycles -> Q=1,2,3,4,5,0,1,2; TC=1 only on the cycle Q=0; Q_GRAY=1,3,2,6,7,0,1,3.
- UP=0, MAX=9, LOAD DIN=2, then EN=1 for 4 cycles -> Q=2,1,0,9,8; TC=1 only when Q=9.
- ONESHOT=1, MAX=3, EN=1 held 6 cycles from Q=0 -> Q=1,2,3,3,3,3; TC pulses once; DONE=1 from the edge of the first terminal step onward. Then LOAD DIN=0 -> DONE=0, counting resumes.
- CLR, LOAD and EN all high with DIN=7 -> Q=0 (CLR wins). Next, LOAD+EN with DIN=7 -> Q=7 (LOAD wins, no step).
- Mid-count (Q=4) drive RST=0 between clock edges -> Q, Q_GRAY, TC and DONE go to 0 before the next edge. On release, the first enabled edge gives Q=1.
- LOAD DIN=12 with MAX=5, up-count -> next Q=0 with TC=1 (DIN>MAX treated as terminal).
